// File: rtl/mux_pkg.sv
// Shared types and sizing for the 8:1 selector leaf.
package mux_pkg;

  localparam int N_IN  = 8;
  localparam int SEL_W = 3;

  typedef logic [N_IN-1:0]  mux_data_t;
  typedef logic [SEL_W-1:0] mux_sel_t;

endpackage : mux_pkg

// File: rtl/mux_8x1_if.sv
// Signal bundle for mux_8x1: data/select/enable in, combinational and registered bit out.
interface mux_8x1_if;

  // en is a level-sensitive load qualifier for z_q; there is no valid/ready
  // handshake and no backpressure: z always follows x[s], z_q loads on en.
  mux_pkg::mux_data_t x;
  mux_pkg::mux_sel_t  s;
  logic               en;
  logic               z;
  logic               z_q;

  modport master (
    output x,
    output s,
    output en,
    input  z,
    input  z_q
  );

  modport slave (
    input  x,
    input  s,
    input  en,
    output z,
    output z_q
  );

endinterface : mux_8x1_if

// File: rtl/mux_2x1.sv
// Single 2:1 selector stage; y = sel ? b : a.
module mux_2x1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule : mux_2x1

// File: rtl/mux_8x1.sv
// 8:1 one-bit selector built as a 3-level 2:1 tree, with a registered copy of the result.
module mux_8x1
  import mux_pkg::*;
#(
  parameter int N_IN_P  = N_IN,
  parameter int SEL_W_P = SEL_W
) (
  input  logic      clk,
  input  logic      rst_n,
  mux_8x1_if.slave  bus
);

  if (N_IN_P != 8 || SEL_W_P != 3) begin : g_bad_size
    $error("mux_8x1 supports only N_IN=8, SEL_W=3");
  end

  logic [N_IN_P/2-1:0] lvl0;
  logic [N_IN_P/4-1:0] lvl1;
  logic                z_tree;
  logic                z_q_r;

  // Level 0 pairs (d1,d0), (d3,d2), (d5,d4), (d7,d6) on s[0].
  for (genvar i = 0; i < N_IN_P/2; i++) begin : g_lvl0
    mux_2x1 u_mux (
      .a   (bus.x[2*i]),
      .b   (bus.x[2*i+1]),
      .sel (bus.s[0]),
      .y   (lvl0[i])
    );
  end

  for (genvar j = 0; j < N_IN_P/4; j++) begin : g_lvl1
    mux_2x1 u_mux (
      .a   (lvl0[2*j]),
      .b   (lvl0[2*j+1]),
      .sel (bus.s[1]),
      .y   (lvl1[j])
    );
  end

  mux_2x1 u_lvl2 (
    .a   (lvl1[0]),
    .b   (lvl1[1]),
    .sel (bus.s[2]),
    .y   (z_tree)
  );

  assign bus.z = z_tree;

  // Reset wins over en; the held bit is discarded as soon as rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q_r <= 1'b0;
    end else if (bus.en) begin
      z_q_r <= z_tree;
    end
  end

  assign bus.z_q = z_q_r;

endmodule : mux_8x1

// File: tb/tb_mux_8x1.sv
// Self-checking bench for mux_8x1: vector table, register/reset sequences, exhaustive and random sweeps.
module tb_mux_8x1;
  import mux_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_8x1_if bus ();

  mux_8x1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] x;
    logic [2:0] s;
    logic       z;
  } vec_t;

  vec_t vecs[$];
  logic exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic model_zq;

  // reference: pick bit s of x by shifting it down to position 0
  function automatic logic ref_sel(input logic [7:0] xv, input int sv);
    logic [7:0] sh;
    sh = xv >> sv;
    return sh[0];
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (x=%h s=%0d en=%b rst_n=%b)",
               name, act, exp, bus.x, bus.s, bus.en, rst_n);
    end
  endtask

  // driver: apply inputs on the falling edge, let z settle
  task automatic drive(input logic [7:0] xv, input logic [2:0] sv, input logic ev);
    @(negedge clk);
    bus.x  = xv;
    bus.s  = sv;
    bus.en = ev;
    #1;
  endtask

  // one scoreboarded cycle: check z, model z_q, check z_q after the edge
  task automatic sb_cycle(input logic [7:0] xv, input logic [2:0] sv, input logic ev);
    drive(xv, sv, ev);
    check("z_sweep", bus.z, ref_sel(xv, int'(sv)));
    if (ev) model_zq = ref_sel(xv, int'(sv));
    exp_q.push_back(model_zq);
    @(posedge clk);
    #1;
    check("z_q_sweep", bus.z_q, exp_q.pop_front());
  endtask

  initial begin
    vec_t v;
    logic [7:0] one;

    for (int i = 0; i < 8; i++) begin
      one = 8'h01 << i;
      v.x = one;  v.s = 3'(i); v.z = 1'b1; vecs.push_back(v);
    end
    for (int i = 0; i < 8; i++) begin
      one = 8'h01 << i;
      v.x = ~one; v.s = 3'(i); v.z = 1'b0; vecs.push_back(v);
    end
    for (int i = 1; i < 8; i++) begin
      v.x = 8'h01; v.s = 3'(i); v.z = 1'b0; vecs.push_back(v);
    end
    for (int i = 0; i < 7; i++) begin
      v.x = 8'h80; v.s = 3'(i); v.z = 1'b0; vecs.push_back(v);
    end

    rst_n  = 1'b0;
    bus.x  = 8'h00;
    bus.s  = 3'd0;
    bus.en = 1'b0;
    #1;
    check("z_q_reset", bus.z_q, 1'b0);

    // table walk while reset is held with en=1: z must work, z_q must stay 0
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].x, vecs[i].s, 1'b1);
      check("z_table", bus.z, vecs[i].z);
      @(posedge clk);
      #1;
      check("z_q_in_reset", bus.z_q, 1'b0);
    end

    // register path
    @(negedge clk);
    rst_n = 1'b1;
    bus.x = 8'h04; bus.s = 3'd2; bus.en = 1'b1;
    #1;
    check("z_load", bus.z, 1'b1);
    @(posedge clk);
    #1;
    check("z_q_load", bus.z_q, 1'b1);

    drive(8'h00, 3'd2, 1'b0);
    check("z_drop", bus.z, 1'b0);
    check("z_q_hold_pre", bus.z_q, 1'b1);
    @(posedge clk);
    #1;
    check("z_q_hold", bus.z_q, 1'b1);

    // async reset between edges
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("z_q_async", bus.z_q, 1'b0);
    bus.x = 8'hFF; bus.en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("z_q_reset_wins", bus.z_q, 1'b0);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    bus.en = 1'b0;
    model_zq = 1'b0;

    // exhaustive x by s with random enable
    for (int xv = 0; xv < 256; xv++) begin
      for (int sv = 0; sv < 8; sv++) begin
        sb_cycle(8'(xv), 3'(sv), 1'($urandom_range(0, 1)));
      end
    end

    // random tail
    for (int i = 0; i < 300; i++) begin
      sb_cycle(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mux_8x1
